// File: rtl/conv_weights_pkg.sv
// Shared widths and FSM state encoding for the convolution weight loader.
package conv_weights_pkg;

  localparam int WEIGHT_WORD_LENGTH = 512;
  localparam int DDR_DATA_WIDTH     = 64;
  localparam int BEATS_PER_WORD     = 8;
  localparam int BUF_ADR_WIDTH      = 16;
  localparam int RD_LEN_WIDTH       = 20;
  localparam int COUNT_WIDTH        = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FILL  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } load_state_t;

endpackage

// File: rtl/conv_weights_loader_packer.sv
// Packs DDR beats into one buffer word; beat 0 ends up least significant.
module weights_word_packer
  import conv_weights_pkg::*;
#(
  parameter int weight_word_length = WEIGHT_WORD_LENGTH,
  parameter int ddr_data_width     = DDR_DATA_WIDTH,
  parameter int beats_per_word     = BEATS_PER_WORD
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          beat_accept,
  input  logic [ddr_data_width-1:0]     beat_data,
  output logic [weight_word_length-1:0] word,
  output logic                          word_full
);

  localparam int CNT_W = (beats_per_word > 1) ? $clog2(beats_per_word) : 1;

  logic [CNT_W-1:0]              beat_cnt_q;
  logic [weight_word_length-1:0] shift_q;

  // New beats enter at the top and move down, so after a full word beat 0 sits at bit 0.
  assign word      = {beat_data, shift_q[weight_word_length-1:ddr_data_width]};
  assign word_full = beat_accept && (beat_cnt_q == CNT_W'(beats_per_word - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_q <= '0;
      shift_q    <= '0;
    end else if (clear) begin
      beat_cnt_q <= '0;
      shift_q    <= '0;
    end else if (beat_accept) begin
      shift_q    <= word;
      beat_cnt_q <= word_full ? '0 : beat_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_weights_loader.sv
// Loads a block of convolution weight words from DDR into the on-chip weight buffer.
module conv_weights_loader
  import conv_weights_pkg::*;
#(
  parameter int weight_word_length = WEIGHT_WORD_LENGTH,
  parameter int ddr_data_width     = DDR_DATA_WIDTH,
  parameter int beats_per_word     = BEATS_PER_WORD
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          conv_load_weights,
  input  logic [31:0]                   weights_ddr_base_adr,
  input  logic [COUNT_WIDTH-1:0]        weights_word_count,
  output logic                          ddr_rd_req,
  output logic [31:0]                   ddr_rd_adr,
  output logic [RD_LEN_WIDTH-1:0]       ddr_rd_len,
  input  logic                          ddr_weights_valid,
  output logic                          ddr_weights_ready,
  input  logic [ddr_data_width-1:0]     ddr_weights_data,
  output logic                          weights_word_buf_en_wt,
  output logic [BUF_ADR_WIDTH-1:0]      weights_word_buf_adr_wt,
  output logic [weight_word_length-1:0] weights_word_buf_wt,
  output logic                          weights_load_busy,
  output logic                          weights_load_done,
  output logic                          weights_load_overrun
);

  // Beat handshake: a beat transfers on a rising clk edge where ddr_weights_valid and
  // ddr_weights_ready are both 1; ready depends only on the FSM state, never on valid.

  load_state_t                   state_q, state_d;
  logic                          reset_sync;
  logic [31:0]                   base_q;
  logic [COUNT_WIDTH-1:0]        count_q;
  logic [BUF_ADR_WIDTH-1:0]      word_idx_q;
  logic [BUF_ADR_WIDTH-1:0]      adr_wt_q;
  logic [weight_word_length-1:0] wt_q;
  logic                          overrun_q;
  logic                          beat_accept;
  logic                          word_full;
  logic [weight_word_length-1:0] packed_word;
  logic [RD_LEN_WIDTH-1:0]       burst_len;

  // Single release stage: a start is first sampled on the second edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) reset_sync <= 1'b0;
    else        reset_sync <= 1'b1;
  end

  assign beat_accept = ddr_weights_valid && ddr_weights_ready;
  assign burst_len   = RD_LEN_WIDTH'(count_q) * RD_LEN_WIDTH'(beats_per_word);

  weights_word_packer #(
    .weight_word_length (weight_word_length),
    .ddr_data_width     (ddr_data_width),
    .beats_per_word     (beats_per_word)
  ) u_packer (
    .clk         (clk),
    .reset       (reset_sync),
    .clear       (state_q == ST_IDLE),
    .beat_accept (beat_accept),
    .beat_data   (ddr_weights_data),
    .word        (packed_word),
    .word_full   (word_full)
  );

  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (conv_load_weights) state_d = (weights_word_count == '0) ? ST_DONE : ST_REQ;
      ST_REQ:   state_d = ST_FILL;
      ST_FILL:  if (word_full) state_d = ST_WRITE;
      ST_WRITE: state_d = (word_idx_q == count_q) ? ST_DONE : ST_FILL;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ddr_rd_req              = 1'b0;
    ddr_rd_adr              = '0;
    ddr_rd_len              = '0;
    ddr_weights_ready       = 1'b0;
    weights_word_buf_en_wt  = 1'b0;
    weights_load_busy       = (state_q != ST_IDLE);
    weights_load_done       = 1'b0;
    case (state_q)
      ST_REQ: begin
        ddr_rd_req = 1'b1;
        ddr_rd_adr = base_q;
        ddr_rd_len = burst_len;
      end
      ST_FILL:  ddr_weights_ready      = 1'b1;
      ST_WRITE: weights_word_buf_en_wt = 1'b1;
      ST_DONE:  weights_load_done      = 1'b1;
      default: ;
    endcase
  end

  assign weights_word_buf_adr_wt = adr_wt_q;
  assign weights_word_buf_wt     = wt_q;
  assign weights_load_overrun    = overrun_q;

  // Write-side registers load on the final beat so the WRITE cycle presents them.
  always_ff @(posedge clk or negedge reset_sync) begin
    if (!reset_sync) begin
      base_q     <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      adr_wt_q   <= '0;
      wt_q       <= '0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= conv_load_weights && (state_q != ST_IDLE);
      if (state_q == ST_IDLE && conv_load_weights) begin
        base_q     <= weights_ddr_base_adr;
        count_q    <= weights_word_count;
        word_idx_q <= '0;
      end
      if (word_full) begin
        wt_q       <= packed_word;
        adr_wt_q   <= word_idx_q;
        word_idx_q <= word_idx_q + BUF_ADR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_weights_loader.sv
// Randomised scenario bench for conv_weights_loader with a word-packing reference model.
module tb_conv_weights_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         conv_load_weights;
  logic [31:0]  weights_ddr_base_adr;
  logic [15:0]  weights_word_count;
  logic         ddr_rd_req;
  logic [31:0]  ddr_rd_adr;
  logic [19:0]  ddr_rd_len;
  logic         ddr_weights_valid;
  logic         ddr_weights_ready;
  logic [63:0]  ddr_weights_data;
  logic         weights_word_buf_en_wt;
  logic [15:0]  weights_word_buf_adr_wt;
  logic [511:0] weights_word_buf_wt;
  logic         weights_load_busy;
  logic         weights_load_done;
  logic         weights_load_overrun;

  conv_weights_loader dut (
    .clk                     (clk),
    .reset                   (reset),
    .conv_load_weights       (conv_load_weights),
    .weights_ddr_base_adr    (weights_ddr_base_adr),
    .weights_word_count      (weights_word_count),
    .ddr_rd_req              (ddr_rd_req),
    .ddr_rd_adr              (ddr_rd_adr),
    .ddr_rd_len              (ddr_rd_len),
    .ddr_weights_valid       (ddr_weights_valid),
    .ddr_weights_ready       (ddr_weights_ready),
    .ddr_weights_data        (ddr_weights_data),
    .weights_word_buf_en_wt  (weights_word_buf_en_wt),
    .weights_word_buf_adr_wt (weights_word_buf_adr_wt),
    .weights_word_buf_wt     (weights_word_buf_wt),
    .weights_load_busy       (weights_load_busy),
    .weights_load_done       (weights_load_done),
    .weights_load_overrun    (weights_load_overrun)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus and observation state
  logic [63:0]  src_q[$];
  logic [63:0]  beat_q[$];
  bit           throttle = 1'b0;
  bit           tog      = 1'b0;
  int           accepted = 0;

  logic [511:0] exp_q[$];
  logic [15:0]  exp_adr_q[$];
  logic [511:0] got_word_q[$];
  logic [15:0]  got_adr_q[$];
  int           got_wcyc_q[$];
  logic [31:0]  rd_adr_q[$];
  logic [19:0]  rd_len_q[$];
  int           cyc = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           overrun_cnt = 0;
  int           busy_cnt = 0;
  int           start_cyc = 0;

  // Beat driver: ready is state-only, so a beat shown with ready=1 at a negedge transfers at the next posedge.
  initial begin
    ddr_weights_valid = 1'b0;
    ddr_weights_data  = '0;
    forever begin
      @(negedge clk);
      tog = ~tog;
      if (reset && beat_q.size() > 0 && (!throttle || tog)) begin
        ddr_weights_valid = 1'b1;
        ddr_weights_data  = beat_q[0];
        if (ddr_weights_ready) begin
          void'(beat_q.pop_front());
          accepted++;
        end
      end else begin
        ddr_weights_valid = 1'b0;
        ddr_weights_data  = {$urandom, $urandom};
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (weights_word_buf_en_wt) begin
        got_word_q.push_back(weights_word_buf_wt);
        got_adr_q.push_back(weights_word_buf_adr_wt);
        got_wcyc_q.push_back(cyc);
      end
      if (ddr_rd_req) begin
        rd_adr_q.push_back(ddr_rd_adr);
        rd_len_q.push_back(ddr_rd_len);
      end
      if (weights_load_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (weights_load_overrun) overrun_cnt++;
      if (weights_load_busy) busy_cnt++;
    end
  end

  task automatic clear_log();
    exp_q.delete(); exp_adr_q.delete();
    got_word_q.delete(); got_adr_q.delete(); got_wcyc_q.delete();
    rd_adr_q.delete(); rd_len_q.delete();
    done_cnt = 0; overrun_cnt = 0; busy_cnt = 0; accepted = 0;
  endtask

  // Reference model: word w holds beat (w*8+k) of the source stream in bits [k*64 +: 64].
  task automatic model_expect(input int first_beat, input int count);
    logic [511:0] w;
    for (int i = 0; i < count; i++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w[k*64 +: 64] = src_q[first_beat + i*8 + k];
      exp_q.push_back(w);
      exp_adr_q.push_back(16'(i));
    end
  endtask

  task automatic fill_random(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back({$urandom, $urandom});
    beat_q = src_q;
  endtask

  task automatic start_load(input logic [31:0] base, input logic [15:0] count);
    @(negedge clk);
    conv_load_weights    = 1'b1;
    weights_ddr_base_adr = base;
    weights_word_count   = count;
    #1 start_cyc = cyc;
    @(negedge clk);
    conv_load_weights    = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound, output bit ok);
    int n = 0;
    while (done_cnt < target && n < bound) begin
      @(negedge clk); #1; n++;
    end
    ok = (done_cnt >= target);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    conv_load_weights = 1'b0;
    weights_ddr_base_adr = '0;
    weights_word_count = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({ddr_rd_req, ddr_rd_adr, ddr_rd_len, ddr_weights_ready, weights_word_buf_en_wt,
         weights_word_buf_adr_wt, weights_word_buf_wt, weights_load_busy, weights_load_done,
         weights_load_overrun} !== '0)
      $display("FAIL reset_outputs got busy=%b ready=%b adr_wt=%h rd_adr=%h (all required 0)",
               weights_load_busy, ddr_weights_ready, weights_word_buf_adr_wt, ddr_rd_adr);
    else n_pass++;
    // Start seen only on the first edge after release must be dropped.
    clear_log();
    @(negedge clk);
    reset = 1'b1;
    conv_load_weights = 1'b1;
    weights_word_count = 16'd0;
    @(negedge clk);
    conv_load_weights = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (done_cnt !== 0) $display("FAIL reset_first_edge_start got done=%0d required 0", done_cnt);
    else n_pass++;
    // Start seen on the second edge after release is taken.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
    reset = 1'b1;
    start_load(32'h0, 16'd0);
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL reset_second_edge_start got done=%0d required 1", done_cnt);
    else n_pass++;
  endtask

  task automatic test_nominal();
    bit ok;
    logic [511:0] w0;
    clear_log();
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(64'(i));
    beat_q = src_q;
    throttle = 1'b0;
    model_expect(0, 2);
    start_load(32'h1000, 16'd2);
    wait_done(1, 200, ok);
    n_checks++;
    if (!ok) $display("FAIL nominal_timeout got done=%0d required 1", done_cnt); else n_pass++;
    n_checks++;
    if (rd_adr_q.size() != 1 || rd_adr_q[0] !== 32'h1000 || rd_len_q[0] !== 20'd16)
      $display("FAIL nominal_rd_req got n=%0d adr=%h len=%0d required n=1 adr=1000 len=16",
               rd_adr_q.size(), rd_adr_q.size() ? rd_adr_q[0] : 32'h0, rd_len_q.size() ? rd_len_q[0] : 20'h0);
    else n_pass++;
    n_checks++;
    if (got_word_q.size() != 2) $display("FAIL nominal_write_count got %0d required 2", got_word_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_word_q.size() <= i || got_word_q[i] !== exp_q[i] || got_adr_q[i] !== exp_adr_q[i])
        $display("FAIL nominal_word%0d got adr=%h word=%h required adr=%h word=%h", i,
                 got_adr_q.size() > i ? got_adr_q[i] : 16'hx, got_word_q.size() > i ? got_word_q[i] : 512'hx,
                 exp_adr_q[i], exp_q[i]);
      else n_pass++;
    end
    w0 = got_word_q.size() > 0 ? got_word_q[0] : '1;
    n_checks++;
    if (w0[63:0] !== 64'h0 || w0[511:448] !== 64'h7)
      $display("FAIL nominal_word0_ends got lo=%h hi=%h required lo=0 hi=7", w0[63:0], w0[511:448]);
    else n_pass++;
    n_checks++;
    if (got_wcyc_q.size() != 2 || done_cyc !== got_wcyc_q[1] + 1)
      $display("FAIL nominal_done_timing got done_cyc=%0d required last_write_cyc+1", done_cyc);
    else n_pass++;
  endtask

  task automatic test_zero_count();
    bit ok;
    clear_log();
    beat_q.delete();
    start_load(32'h2000, 16'd0);
    wait_done(1, 50, ok);
    n_checks++;
    if (!ok || done_cnt !== 1) $display("FAIL zero_done_count got %0d required 1", done_cnt); else n_pass++;
    n_checks++;
    if (rd_adr_q.size() != 0 || got_word_q.size() != 0)
      $display("FAIL zero_no_traffic got rd=%0d wr=%0d required 0 0", rd_adr_q.size(), got_word_q.size());
    else n_pass++;
    // Start driven in cycle 1, done visible in cycle 2.
    n_checks++;
    if (done_cyc !== start_cyc + 1)
      $display("FAIL zero_done_latency got %0d required %0d", done_cyc - start_cyc, 1);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== 1) $display("FAIL zero_busy_cycles got %0d required 1", busy_cnt); else n_pass++;
  endtask

  task automatic test_throttled();
    bit ok;
    clear_log();
    fill_random(8);
    throttle = 1'b1;
    model_expect(0, 1);
    start_load($urandom, 16'd1);
    wait_done(1, 200, ok);
    throttle = 1'b0;
    n_checks++;
    if (!ok || got_word_q.size() != 1)
      $display("FAIL throttle_write_count got %0d required 1", got_word_q.size());
    else n_pass++;
    n_checks++;
    if (got_word_q.size() < 1 || got_word_q[0] !== exp_q[0] || got_adr_q[0] !== 16'd0)
      $display("FAIL throttle_word got %h required %h", got_word_q.size() ? got_word_q[0] : 512'hx, exp_q[0]);
    else n_pass++;
    n_checks++;
    if (rd_len_q.size() != 1 || rd_len_q[0] !== 20'd8)
      $display("FAIL throttle_rd_len got %0d required 8", rd_len_q.size() ? rd_len_q[0] : 20'h0);
    else n_pass++;
  endtask

  task automatic test_overrun();
    bit ok;
    int n = 0;
    logic [31:0] base;
    clear_log();
    fill_random(16);
    base = $urandom;
    model_expect(0, 2);
    start_load(base, 16'd2);
    while (!ddr_weights_ready && n < 20) begin @(negedge clk); #1; n++; end
    start_load(32'hDEAD_0000, 16'd5);
    wait_done(1, 200, ok);
    n_checks++;
    if (overrun_cnt !== 1) $display("FAIL overrun_pulses got %0d required 1", overrun_cnt); else n_pass++;
    n_checks++;
    if (!ok || got_word_q.size() != 2 || rd_adr_q.size() != 1 || rd_adr_q[0] !== base)
      $display("FAIL overrun_load got wr=%0d rd=%0d required wr=2 rd=1", got_word_q.size(), rd_adr_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_word_q.size() <= i || got_word_q[i] !== exp_q[i] || got_adr_q[i] !== exp_adr_q[i])
        $display("FAIL overrun_word%0d got %h required %h", i,
                 got_word_q.size() > i ? got_word_q[i] : 512'hx, exp_q[i]);
      else n_pass++;
    end
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL overrun_single_done got %0d required 1", done_cnt); else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int n = 0;
    clear_log();
    fill_random(16);
    start_load($urandom, 16'd2);
    while (accepted < 3 && n < 50) begin @(negedge clk); #1; n++; end
    reset = 1'b0;
    beat_q.delete();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (weights_load_busy !== 1'b0 || weights_word_buf_wt !== '0)
      $display("FAIL midreset_cleared got busy=%b wt_nonzero=%b required 0 0",
               weights_load_busy, |weights_word_buf_wt);
    else n_pass++;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (got_word_q.size() != 0 || done_cnt !== 0)
      $display("FAIL midreset_abandon got wr=%0d done=%0d required 0 0", got_word_q.size(), done_cnt);
    else n_pass++;
    clear_log();
    fill_random(8);
    model_expect(0, 1);
    start_load($urandom, 16'd1);
    wait_done(1, 200, ok);
    n_checks++;
    if (!ok || got_word_q.size() != 1 || got_adr_q[0] !== 16'd0 || got_word_q[0] !== exp_q[0])
      $display("FAIL midreset_new_load got wr=%0d word=%h required 1 %h", got_word_q.size(),
               got_word_q.size() ? got_word_q[0] : 512'hx, exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    fill_random(24);
    model_expect(0, 2);
    model_expect(16, 1);
    start_load($urandom, 16'd2);
    while (done_cnt < 1 && n_checks >= 0) begin
      @(negedge clk); #1;
      if (cyc - start_cyc > 200) break;
    end
    // Start in the cycle right after the done pulse.
    start_load($urandom, 16'd1);
    wait_done(2, 200, ok);
    n_checks++;
    if (!ok || overrun_cnt !== 0)
      $display("FAIL b2b_accept got done=%0d overrun=%0d required 2 0", done_cnt, overrun_cnt);
    else n_pass++;
    n_checks++;
    if (rd_len_q.size() != 2 || rd_len_q[0] !== 20'd16 || rd_len_q[1] !== 20'd8)
      $display("FAIL b2b_rd_len got n=%0d required 2 bursts 16,8", rd_len_q.size());
    else n_pass++;
    n_checks++;
    if (got_word_q.size() != 3) $display("FAIL b2b_write_count got %0d required 3", got_word_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (got_word_q.size() <= i || got_word_q[i] !== exp_q[i] || got_adr_q[i] !== exp_adr_q[i])
        $display("FAIL b2b_word%0d got adr=%h required adr=%h", i,
                 got_adr_q.size() > i ? got_adr_q[i] : 16'hx, exp_adr_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_count();
    test_throttled();
    test_overrun();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
